// File: rtl/mul_test_pkg.sv
// Shared types and helpers for the multiplier test sequencer: state encoding,
// LFSR operand generator step and MISR signature fold.
package mul_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN_A,
        ST_GEN_B,
        ST_LAUNCH,
        ST_WAIT,
        ST_CAPTURE,
        ST_FINISH
    } state_t;

    localparam logic [31:0] LFSR_TAP  = 32'h80200003;
    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

    // Galois LFSR, right shift
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAP : 32'h0);
    endfunction

    function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [31:0] d);
        return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ d;
    endfunction

endpackage

// File: rtl/mul_test_misr.sv
// 32-bit multiple-input signature register with synchronous clear and enable;
// shared by the board self-test sequencers.
module mul_test_misr
    import mul_test_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] data,
    output logic [31:0] signature
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            signature <= '0;
        end else if (enable) begin
            signature <= misr_next(signature, data);
        end
    end

endmodule

// File: rtl/mul_test_sequencer.sv
// Drives NUM_OPS LFSR operand pairs into the multiplier under test and folds
// each result into a MISR. Optional WAIT timeout enabled by MULSEQ_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for run
// GEN_A      | step LFSR, load operand A
// GEN_B      | step LFSR, load operand B and mode bits
// LAUNCH     | mul_start high, arm latency timer
// WAIT       | wait for mul_done and minimum latency
// CAPTURE    | fold result into signature, count op
// FINISH     | end of run, done pulse follows
module mul_test_sequencer
    import mul_test_pkg::*;
#(
    parameter int unsigned NUM_OPS = 64,
    parameter logic [31:0] SEED    = 32'h00000001,
    parameter int unsigned MIN_LAT = 4
`ifdef MULSEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 255
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [31:0] inpA,
    output logic [31:0] inpB,
    output logic        a_signed,
    output logic        b_signed,
    output logic        mul_type,
    output logic        mul_start,
    input  logic [31:0] mul_out,
    input  logic        mul_done,
    output logic        busy,
    output logic        done,
    output logic [31:0] signature,
    output logic [15:0] op_count,
    output logic        err
);

    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h00000001 : SEED;
    localparam logic [15:0] LAT_INIT  = 16'(MIN_LAT);
    localparam logic [16:0] NUM_OPS_W = 17'(NUM_OPS);

    state_t      state;
    logic [31:0] lfsr;
    logic [31:0] lfsr_step;
    logic [15:0] lat_rem;
    logic [15:0] lat_dec;
    logic        lat_ok;
    logic        seen_done;
    logic        seen_now;
    logic [16:0] count_inc;
    logic        misr_clear;
    logic        misr_en;
    logic        to_hit;

    assign lfsr_step  = lfsr_next(lfsr);
    assign lat_dec    = (lat_rem == 16'd0) ? 16'd0 : lat_rem - 16'd1;
    assign lat_ok     = (lat_dec == 16'd0);
    // a done arriving in this WAIT cycle counts immediately
    assign seen_now   = seen_done | mul_done;
    assign count_inc  = {1'b0, op_count} + 17'd1;
    assign misr_clear = (state == ST_IDLE) && run;
    assign misr_en    = (state == ST_CAPTURE);

`ifdef MULSEQ_TIMEOUT_EN
    localparam logic [15:0] TO_INIT = 16'(TIMEOUT);

    logic [15:0] to_rem;
    logic        err_q;

    // terminal count reached on the TIMEOUT-th WAIT cycle
    assign to_hit = (to_rem == 16'd1) && !seen_now;
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_rem <= '0;
            err_q  <= 1'b0;
        end else if ((state == ST_IDLE) && run) begin
            err_q <= 1'b0;
        end else if (state == ST_LAUNCH) begin
            to_rem <= TO_INIT;
        end else if (state == ST_WAIT) begin
            if (to_rem != 16'd0) begin
                to_rem <= to_rem - 16'd1;
            end
            if (to_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            lfsr      <= SEED_EFF;
            inpA      <= '0;
            inpB      <= '0;
            a_signed  <= 1'b0;
            b_signed  <= 1'b0;
            mul_type  <= 1'b0;
            mul_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            op_count  <= '0;
            lat_rem   <= '0;
            seen_done <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        op_count <= '0;
                        busy     <= 1'b1;
                        state    <= ST_GEN_A;
                    end
                end
                ST_GEN_A: begin
                    lfsr  <= lfsr_step;
                    inpA  <= lfsr_step;
                    state <= ST_GEN_B;
                end
                ST_GEN_B: begin
                    lfsr      <= lfsr_step;
                    inpB      <= lfsr_step;
                    a_signed  <= op_count[0];
                    b_signed  <= op_count[1];
                    mul_type  <= op_count[2];
                    mul_start <= 1'b1;
                    state     <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    lat_rem   <= LAT_INIT;
                    seen_done <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    lat_rem   <= lat_dec;
                    seen_done <= seen_now;
                    if (seen_now && lat_ok) begin
                        state <= ST_CAPTURE;
                    end else if (to_hit) begin
                        state <= ST_FINISH;
                    end
                end
                ST_CAPTURE: begin
                    op_count <= count_inc[15:0];
                    state    <= (count_inc < NUM_OPS_W) ? ST_GEN_A : ST_FINISH;
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mul_test_misr u_misr (
        .clk       (clk),
        .reset     (reset),
        .clear     (misr_clear),
        .enable    (misr_en),
        .data      (mul_out),
        .signature (signature)
    );

endmodule

// File: tb/tb_mul_test_sequencer.sv
// Self-checking bench for mul_test_sequencer: multiplier stub with programmable
// done latency, behavioural operand/signature model, directed run sequence.
module tb_mul_test_sequencer;

    localparam int NUM_OPS_V = 6;
    localparam int MIN_LAT_V = 4;
    localparam int TIMEOUT_V = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] inpA;
    logic [31:0] inpB;
    logic        a_signed;
    logic        b_signed;
    logic        mul_type;
    logic        mul_start;
    logic [31:0] mul_out = 32'h0;
    logic        mul_done = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] signature;
    logic [15:0] op_count;
    logic        err;

    int checks = 0;
    int errors = 0;

    mul_test_sequencer #(
        .NUM_OPS (NUM_OPS_V),
        .SEED    (32'h00000001),
        .MIN_LAT (MIN_LAT_V)
`ifdef MULSEQ_TIMEOUT_EN
        ,
        .TIMEOUT (TIMEOUT_V)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .inpA      (inpA),
        .inpB      (inpB),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .mul_type  (mul_type),
        .mul_start (mul_start),
        .mul_out   (mul_out),
        .mul_done  (mul_done),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .op_count  (op_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] m_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] m_misr(input logic [31:0] sig, input logic [31:0] d);
        return (sig << 1) ^ (sig[31] ? 32'h04C11DB7 : 32'h0) ^ d;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic as, input logic bs, input logic hi);
        logic signed [63:0] x, y, p;
        x = as ? {{32{a[31]}}, a} : {32'h0, a};
        y = bs ? {{32{b[31]}}, b} : {32'h0, b};
        p = x * y;
        return hi ? p[63:32] : p[31:0];
    endfunction

    // ---------------- multiplier stub ----------------
    int          stub_lat = 1;     // 0 = never completes
    bit          stub_const = 1'b1;
    int          stub_cnt = 0;
    bit          stub_armed = 1'b0;
    logic [31:0] stub_res = 32'h0;

    always @(negedge clk) begin
        mul_done = 1'b0;
        if (mul_start === 1'b1) begin
            stub_armed = (stub_lat > 0);
            stub_cnt   = stub_lat;
            stub_res   = stub_const ? 32'h1 : ref_mul(inpA, inpB, a_signed, b_signed, mul_type);
            mul_out    = ~stub_res;
        end else if (stub_armed) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) begin
                mul_done   = 1'b1;
                mul_out    = stub_res;
                stub_armed = 1'b0;
            end
        end
    end

    int done_cnt = 0;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // ---------------- model state ----------------
    logic [31:0] m_lfsr = 32'h1;
    logic [31:0] m_sig  = 32'h0;
    int          m_count = 0;
    logic [31:0] last_a, last_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        m_sig   = 32'h0;
        m_count = 0;
    endtask

    task automatic wait_launch(input string tag);
        int n;
        n = 0;
        while (mul_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check(tag, mul_start, 1'b1);
    endtask

    task automatic do_op(input int lat, input bit cst);
        int          n, bad, w;
        logic [15:0] old;
        logic [31:0] res;
        logic        ma, mb, mt;
        stub_lat   = lat;
        stub_const = cst;
        wait_launch("launch_seen");
        m_lfsr = m_next(m_lfsr);
        last_a = m_lfsr;
        m_lfsr = m_next(m_lfsr);
        last_b = m_lfsr;
        ma = (m_count & 1) != 0;
        mb = (m_count & 2) != 0;
        mt = (m_count & 4) != 0;
        check("op_inpA", inpA, last_a);
        check("op_inpB", inpB, last_b);
        check("op_modes", {a_signed, b_signed, mul_type}, {ma, mb, mt});
        res   = cst ? 32'h1 : ref_mul(last_a, last_b, ma, mb, mt);
        m_sig = m_misr(m_sig, res);
        old = op_count;
        n   = 0;
        bad = 0;
        do begin
            step();
            n++;
            if (op_count === old && (mul_start !== 1'b0 || busy !== 1'b1)) bad++;
        end while (op_count === old && n < 600);
        w = (lat > MIN_LAT_V) ? lat : MIN_LAT_V;
        check("op_latency", n, w + 2);
        check("op_quiet", bad, 0);
        m_count++;
        check("op_count", op_count, m_count);
        check("op_signature", signature, m_sig);
    endtask

    task automatic end_run();
        int d0;
        d0 = done_cnt;
        step();
        check("done_pulse", done, 1'b1);
        check("done_busy_low", busy, 1'b0);
        step();
        check("done_single", done, 1'b0);
        check("done_count", done_cnt - d0, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_start"}, mul_start, 1'b0);
        check({tag, "_inp"}, {inpA, inpB}, 64'h0);
        check({tag, "_modes"}, {a_signed, b_signed, mul_type}, 3'b000);
        check({tag, "_sig"}, signature, 32'h0);
        check({tag, "_count"}, op_count, 16'h0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d_before;
        reset = 1'b1;
        run   = 1'b0;
        repeat (3) step();
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        step();
        check_zero("post_reset");

        // run A: constant results, fast done
        start_run();
        do_op(1, 1'b1);
        check("op0_inpA", last_a, 32'h80200003);
        check("op0_inpB", last_b, 32'hC0300002);
        check("op0_sig", signature, 32'h00000001);
        do_op(1, 1'b1);
        check("op1_sig", signature, 32'h00000003);
        check("op1_modes", {a_signed, b_signed, mul_type}, 3'b100);
        for (int i = 2; i < NUM_OPS_V; i++) do_op(1, 1'b1);
        end_run();

        // run B: true products, random done latency
        start_run();
        for (int i = 0; i < NUM_OPS_V; i++) do_op(int'($urandom_range(1, 8)), 1'b0);
        end_run();

        // run C: slow multiplier
        start_run();
        for (int i = 0; i < NUM_OPS_V; i++) do_op(20, 1'b0);
        end_run();

`ifdef MULSEQ_TIMEOUT_EN
        start_run();
        stub_lat   = 0;
        stub_const = 1'b1;
        wait_launch("to_launch");
        m_lfsr = m_next(m_next(m_lfsr));
        n = 0;
        do begin
            step();
            n++;
        end while (done !== 1'b1 && n < 600);
        check("to_latency", n, TIMEOUT_V + 2);
        check("to_err", err, 1'b1);
        check("to_done", done, 1'b1);
        check("to_opcount", op_count, 16'h0);
        step();
        check("to_err_sticky", err, 1'b1);
`endif

        // run D: reset in WAIT of op 3
        start_run();
        step();
        check("run_err_clear", err, 1'b0);
        for (int i = 0; i < 3; i++) do_op(3, 1'b0);
        stub_lat = 6;
        wait_launch("op3_launch");
        step();
        step();
        d_before = done_cnt;
        @(negedge clk);
        reset = 1'b1;
        step();
        check_zero("abort");
        repeat (3) step();
        check("abort_no_done", done_cnt, d_before);
        @(negedge clk);
        reset  = 1'b0;
        m_lfsr = 32'h1;

        // run E: fresh run reproduces seed operands
        start_run();
        do_op(2, 1'b0);
        check("reseed_inpA", last_a, 32'h80200003);
        check("reseed_inpB", last_b, 32'hC0300002);
        for (int i = 1; i < NUM_OPS_V; i++) do_op(int'($urandom_range(1, 6)), 1'b0);
        end_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
